// File: rtl/train_seq_ctrl.sv
// Purpose : training-sample sequencer; steps ROM address per sample, offers each
//           sample to the NN datapath, waits for backprop done, repeats max_epoch epochs.
// Latency : all outputs registered; sample data valid one cycle after FETCH;
//           minimum 4 cycles per sample.
// Backpressure: sample_valid and rd_en hold (addr stable) until sample_ready;
//               rd_en then stays high through WAIT until nn_done.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start, abort       rising-edge training start; synchronous abort to IDLE
//   max_epoch          epoch count, latched on start
//   sample_ready       datapath accepts the offered sample
//   nn_done            one-cycle pulse, backprop for current sample finished
//   rd_en, addr        shared ROM read enable / sample index
//   sample_valid       sample offered to datapath
//   epoch_cnt          completed epochs
//   busy, done         training in progress / finished
module train_seq_ctrl #(
  parameter int AWIDTH  = 4,
  parameter int NSAMPLE = 4,
  parameter int EPOCH_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [EPOCH_W-1:0] max_epoch,
  input  logic               sample_ready,
  input  logic               nn_done,
  output logic               rd_en,
  output logic [AWIDTH-1:0]  addr,
  output logic               sample_valid,
  output logic [EPOCH_W-1:0] epoch_cnt,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_VALID = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(NSAMPLE - 1);

  state_t               state, state_nx;
  logic                 start_d;
  logic [EPOCH_W-1:0]   max_lat, max_nx;
  logic [AWIDTH-1:0]    addr_nx;
  logic [EPOCH_W-1:0]   epoch_nx;
  logic [EPOCH_W-1:0]   epoch_inc;

  assign epoch_inc = epoch_cnt + EPOCH_W'(1);

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    epoch_nx = epoch_cnt;
    max_nx   = max_lat;
    if (abort) begin
      // epoch_cnt deliberately kept so software can see how far training got
      state_nx = S_IDLE;
      addr_nx  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !start_d) begin
            max_nx   = max_epoch;
            epoch_nx = '0;
            addr_nx  = '0;
            state_nx = (max_epoch == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: state_nx = S_VALID;
        // nn_done is not looked at here: a stray pulse before acceptance is ignored
        S_VALID: if (sample_ready) state_nx = S_WAIT;
        S_WAIT:  if (nn_done) state_nx = S_NEXT;
        S_NEXT: begin
          // address/epoch advance on leaving NEXT, so addr still names the
          // finished sample while rd_en is low
          if (addr == LAST_ADDR) begin
            addr_nx  = '0;
            epoch_nx = epoch_inc;
            state_nx = (epoch_inc == max_lat) ? S_DONE : S_FETCH;
          end else begin
            addr_nx  = addr + AWIDTH'(1);
            state_nx = S_FETCH;
          end
        end
        S_DONE:  if (!start) state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      start_d      <= 1'b0;
      max_lat      <= '0;
      addr         <= '0;
      epoch_cnt    <= '0;
      rd_en        <= 1'b0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nx;
      // start_d tracks start in every state, so a level held across DONE->IDLE
      // is never seen as a new rising edge
      start_d      <= start;
      max_lat      <= max_nx;
      addr         <= addr_nx;
      epoch_cnt    <= epoch_nx;
      // ROM tri-states when rd_en is low, so it spans FETCH through WAIT
      rd_en        <= (state_nx == S_FETCH) || (state_nx == S_VALID) ||
                      (state_nx == S_WAIT);
      sample_valid <= (state_nx == S_VALID);
      busy         <= (state_nx != S_IDLE) && (state_nx != S_DONE);
      done         <= (state_nx == S_DONE);
    end
  end

endmodule
